// File: rtl/rv32_mod_fetch.sv
// ============================================================================
// rv32_mod_fetch: single-outstanding instruction fetch unit with redirect/drain
// Revision: 1.0
// ============================================================================
`default_nettype none

module rv32_mod_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_FETCH = 3'd1;
  localparam logic [2:0] c_WAIT  = 3'd2;
  localparam logic [2:0] c_HOLD  = 3'd3;
  localparam logic [2:0] c_DRAIN = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] pc_seq;

  assign pc_seq      = {pc_q[31:2], 2'b00} + 32'd4;
  assign imem_req    = (state_q == c_FETCH);
  assign imem_addr   = {pc_q[31:2], 2'b00};
  assign instr_valid = (state_q == c_HOLD);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    case (state_q)
      c_IDLE: state_d = c_FETCH;
      c_FETCH: begin
        if (branch_taken) begin
          pc_d = branch_target;
          // Request already accepted: its response is now stale and must be drained.
          if (imem_ack) state_d = c_DRAIN;
        end else if (imem_ack) begin
          state_d = c_WAIT;
        end
      end
      c_WAIT: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = imem_rvalid ? c_FETCH : c_DRAIN;
        end else if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = c_HOLD;
        end
      end
      c_HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = c_FETCH;
        end else if (instr_ready) begin
          pc_d    = pc_seq;
          state_d = c_FETCH;
        end
      end
      c_DRAIN: begin
        if (branch_taken) pc_d = branch_target;
        if (imem_rvalid) state_d = c_FETCH;
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32_mod_fetch.sv
// ============================================================================
// tb_rv32_mod_fetch: directed vector table, corner sequences and a randomized
// comparison against a transaction-level fetch model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rv32_mod_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        imem_ack = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_ready = 1'b0;

  logic        a_req, a_valid, b_req, b_valid;
  logic [31:0] a_addr, a_instr, a_ipc, b_addr, b_instr, b_ipc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv32_mod_fetch #(.RESET_PC(32'h0000_0000)) u_dut_a (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ack(imem_ack), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(a_valid), .instr_ready(instr_ready),
    .instr(a_instr), .instr_pc(a_ipc)
  );

  rv32_mod_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_b (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ack(imem_ack), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_valid(b_valid), .instr_ready(instr_ready),
    .instr(b_instr), .instr_pc(b_ipc)
  );

  // Model tracks the fetch as transactions: a pending response, whether it is
  // condemned by a redirect, and whether an instruction is held for decode.
  typedef struct {
    logic        start, pend, disc, have;
    logic [31:0] pc, ins, ipc;
  } mdl_t;

  typedef struct {
    logic        rst, br;
    logic [31:0] tgt;
    logic        ack, rv;
    logic [31:0] rd;
    logic        rdy;
    logic        req, valid;
    logic [31:0] addr, ins, ipc;
  } vec_t;

  vec_t vecs[$];
  mdl_t ma, mb;

  function automatic vec_t mk(logic r, logic br, logic [31:0] tgt, logic ack, logic rv,
                              logic [31:0] rd, logic rdy, logic req, logic valid,
                              logic [31:0] addr, logic [31:0] ins, logic [31:0] ipc);
    vec_t v;
    v.rst = r; v.br = br; v.tgt = tgt; v.ack = ack; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.req = req; v.valid = valid; v.addr = addr; v.ins = ins; v.ipc = ipc;
    return v;
  endfunction

  function automatic mdl_t step(mdl_t m, logic r, logic [31:0] rpc);
    mdl_t n = m;
    if (r) begin
      n.start = 1'b1; n.pend = 1'b0; n.disc = 1'b0; n.have = 1'b0;
      n.pc = rpc; n.ins = 32'd0; n.ipc = 32'd0;
    end else if (m.start) begin
      n.start = 1'b0;
    end else if (m.have) begin
      if (branch_taken) begin
        n.pc = branch_target; n.have = 1'b0;
      end else if (instr_ready) begin
        n.pc = (m.pc & 32'hFFFF_FFFC) + 32'd4; n.have = 1'b0;
      end
    end else if (m.pend) begin
      if (imem_rvalid) begin
        if (!m.disc && !branch_taken) begin
          n.ins = imem_rdata; n.ipc = m.pc; n.have = 1'b1;
        end
        n.pend = 1'b0; n.disc = 1'b0;
      end else if (branch_taken) begin
        n.disc = 1'b1;
      end
      if (branch_taken) n.pc = branch_target;
    end else begin
      if (imem_ack) begin
        n.pend = 1'b1; n.disc = branch_taken;
      end
      if (branch_taken) n.pc = branch_target;
    end
    return n;
  endfunction

  function automatic logic [97:0] expect_of(mdl_t m);
    return {!m.start && !m.pend && !m.have, m.have, m.pc & 32'hFFFF_FFFC, m.ins, m.ipc};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic br, logic [31:0] tgt, logic ack, logic rv,
                       logic [31:0] rd, logic rdy);
    rst = r; branch_taken = br; branch_target = tgt;
    imem_ack = ack; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy;
  endtask

  initial begin
    // Directed table against the RESET_PC=0 instance.
    vecs.push_back(mk(1,0,0,0,0,0,0,                 0,0,32'h0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,                 1,0,32'h0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,                 0,0,32'h0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h13,0,            0,1,32'h0,32'h13,0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,1,1,32'hDEADBEEF,0,    0,1,32'h0,32'h13,0));
    vecs.push_back(mk(0,0,0,0,0,0,1,                 1,0,32'h4,32'h13,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,                 1,0,32'h4,32'h13,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,                 0,0,32'h4,32'h13,0));
    vecs.push_back(mk(0,1,32'h102,0,0,0,0,           0,0,32'h100,32'h13,0));
    vecs.push_back(mk(0,0,0,0,1,32'hBAD0BAD0,0,      1,0,32'h100,32'h13,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,                 0,0,32'h100,32'h13,0));
    vecs.push_back(mk(0,0,0,0,1,32'h00500093,0,      0,1,32'h100,32'h00500093,32'h102));
    vecs.push_back(mk(0,1,32'h200,0,0,0,1,           1,0,32'h200,32'h00500093,32'h102));
    vecs.push_back(mk(0,1,32'h300,0,0,0,0,           1,0,32'h300,32'h00500093,32'h102));
    vecs.push_back(mk(0,0,0,1,0,0,0,                 0,0,32'h300,32'h00500093,32'h102));
    vecs.push_back(mk(0,0,0,0,1,32'h11,0,            0,1,32'h300,32'h11,32'h300));
    vecs.push_back(mk(0,0,0,0,0,0,1,                 1,0,32'h304,32'h11,32'h300));
    vecs.push_back(mk(0,0,0,1,0,0,0,                 0,0,32'h304,32'h11,32'h300));
    vecs.push_back(mk(1,0,0,0,0,0,0,                 0,0,32'h0,0,0));
    vecs.push_back(mk(0,1,32'h500,0,1,32'hBEEF,0,    1,0,32'h0,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'hBEEF,0,          1,0,32'h0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,                 0,0,32'h0,0,0));
    vecs.push_back(mk(0,1,32'h40,0,0,0,0,            0,0,32'h40,0,0));
    vecs.push_back(mk(0,1,32'h80,0,0,0,0,            0,0,32'h80,0,0));
    vecs.push_back(mk(0,1,32'hC0,0,1,32'h77,0,       1,0,32'hC0,0,0));
    vecs.push_back(mk(0,1,32'h10,1,0,0,0,            0,0,32'h10,0,0));
    vecs.push_back(mk(0,0,0,0,1,32'h55,0,            1,0,32'h10,0,0));
    vecs.push_back(mk(0,0,0,1,0,0,0,                 0,0,32'h10,0,0));
    vecs.push_back(mk(0,1,32'h20,0,1,32'h66,0,       1,0,32'h20,0,0));

    #2;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].br, vecs[i].tgt, vecs[i].ack, vecs[i].rv, vecs[i].rd, vecs[i].rdy);
      tick();
      chk($sformatf("vec%0d", i),
          {30'd0, a_req, a_valid, a_addr, a_instr, a_ipc},
          {30'd0, vecs[i].req, vecs[i].valid, vecs[i].addr, vecs[i].ins, vecs[i].ipc});
    end

    // Wrap of the sequential increment from the top of the address space.
    drive(1,0,0,0,0,0,0); tick();
    chk("wrap_reset", {b_req, b_addr}, {1'b0, 32'hFFFF_FFFC});
    drive(0,0,0,0,0,0,0); tick();
    chk("wrap_first_req", {b_req, b_addr}, {1'b1, 32'hFFFF_FFFC});
    drive(0,0,0,1,0,0,0); tick();
    drive(0,0,0,0,1,32'h13,0); tick();
    chk("wrap_hold", {b_valid, b_instr, b_ipc}, {1'b1, 32'h13, 32'hFFFF_FFFC});
    drive(0,0,0,0,0,0,1); tick();
    chk("wrap_next_addr", {b_req, b_valid, b_addr}, {1'b1, 1'b0, 32'h0});

    // Randomized run of both instances against the transaction model.
    for (int c = 0; c < 3000; c++) begin
      drive((c == 0) || ($urandom_range(63) == 0), $urandom_range(5) == 0, $urandom,
            $urandom_range(1) == 1, $urandom_range(1) == 1, $urandom, $urandom_range(1) == 1);
      ma = step(ma, rst, 32'h0000_0000);
      mb = step(mb, rst, 32'hFFFF_FFFC);
      tick();
      chk($sformatf("rand_a%0d", c), {30'd0, a_req, a_valid, a_addr, a_instr, a_ipc},
          {30'd0, expect_of(ma)});
      chk($sformatf("rand_b%0d", c), {30'd0, b_req, b_valid, b_addr, b_instr, b_ipc},
          {30'd0, expect_of(mb)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
